// File: rtl/seg7_disp_arb_if.sv
// rtl/seg7_disp_arb_if.sv - requester-side bus of the seven-segment display arbiter
//
// Carries both requester ports (port 0 = CPU, port 1 = debug monitor):
//   reqN   : port N requests display ownership
//   wrN    : port N write strobe
//   addrN  : port N register address (0 di, 1 pixels lo, 2 pixels hi, 3 mode)
//   wdataN : port N write data
//   gntN   : port N currently owns the display (driven by the arbiter)
// Modports: master = requester side, slave = arbiter side.

interface seg7_disp_arb_if;
    logic        req0;
    logic        wr0;
    logic [1:0]  addr0;
    logic [31:0] wdata0;
    logic        gnt0;
    logic        req1;
    logic        wr1;
    logic [1:0]  addr1;
    logic [31:0] wdata1;
    logic        gnt1;

    modport master (
        output req0, wr0, addr0, wdata0,
        output req1, wr1, addr1, wdata1,
        input  gnt0, gnt1
    );

    modport slave (
        input  req0, wr0, addr0, wdata0,
        input  req1, wr1, addr1, wdata1,
        output gnt0, gnt1
    );
endinterface

// File: rtl/seg7_disp_arb.sv
// rtl/seg7_disp_arb.sv - round-robin arbiter and register front-end for the 2x4 seven-segment display
//
// Shares the display between port 0 (CPU) and port 1 (debug monitor). The
// granted port writes the di / pixels / mode registers; a hold-time limit
// stops one port from keeping the display while the other is waiting.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : seg7_disp_arb_if.slave, both requester ports and their grants
//   di     : hex digit data to the display
//   pixels : segment bitmaps to the display
//   direct : 1 = display shows pixels, 0 = display decodes di
//
// Parameters:
//   HOLD_MAX  : cycles an owner may keep the grant while the other port waits (0 = unlimited)
//   BLINK_DIV : cycles per blink half-period (blink build only)
//
// Optional feature: define SEG7_DISP_ARB_BLINK_EN to add the mode-register
// blink_en bit and a blink phase that blanks the display every other period.

module seg7_disp_arb #(
    parameter int HOLD_MAX  = 1024,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    seg7_disp_arb_if.slave      bus,
    output logic [31:0]         di,
    output logic [63:0]         pixels,
    output logic                direct
);

    if (HOLD_MAX < 0) begin : g_bad_hold_max
        $error("HOLD_MAX must be >= 0");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("BLINK_DIV must be >= 1");
    end

    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            last_owner;
    logic [CW-1:0]   hold_cnt;
    logic            other_req;
    logic            hold_expired;

    logic            wr_en;
    logic [1:0]      wr_addr;
    logic [31:0]     wr_data;

    logic [31:0]     di_q;
    logic [63:0]     pix_q;
    logic            dir_q;

    // Request of the port that does not currently own the display.
    always_comb begin
        other_req = 1'b0;
        if (state == OWN0) other_req = bus.req1;
        if (state == OWN1) other_req = bus.req0;
    end

    assign hold_expired = (HOLD_MAX != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) state_nx = last_owner ? OWN0 : OWN1;
                else if (bus.req0)        state_nx = OWN0;
                else if (bus.req1)        state_nx = OWN1;
            end
            OWN0: begin
                if (!bus.req0)                     state_nx = bus.req1 ? OWN1 : IDLE;
                else if (bus.req1 && hold_expired) state_nx = OWN1;
            end
            OWN1: begin
                if (!bus.req1)                     state_nx = bus.req0 ? OWN0 : IDLE;
                else if (bus.req0 && hold_expired) state_nx = OWN0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                hold_cnt <= '0;
                if (state_nx != IDLE) last_owner <= (state_nx == OWN1);
            end else if (other_req && (hold_cnt != HOLD_LAST)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign bus.gnt0 = (state == OWN0);
    assign bus.gnt1 = (state == OWN1);

    // Grants are exclusive, so the write path just follows the current owner.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.addr0;
        wr_data = bus.wdata0;
        if (state == OWN0) begin
            wr_en = bus.wr0;
        end else if (state == OWN1) begin
            wr_en   = bus.wr1;
            wr_addr = bus.addr1;
            wr_data = bus.wdata1;
        end
    end

`ifdef SEG7_DISP_ARB_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic            blink_en;
    logic [BW-1:0]   blink_cnt;
    logic            phase;
    logic            blank;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            di_q     <= '0;
            pix_q    <= '0;
            dir_q    <= 1'b0;
            blink_en <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0: di_q         <= wr_data;
                2'd1: pix_q[31:0]  <= wr_data;
                2'd2: pix_q[63:32] <= wr_data;
                default: begin
                    dir_q    <= wr_data[0];
                    blink_en <= wr_data[1];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Blanking forces pixel mode with every segment dark; stored values are untouched.
    assign blank  = blink_en && phase;
    assign di     = di_q;
    assign direct = dir_q | blank;
    assign pixels = blank ? 64'd0 : pix_q;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            di_q  <= '0;
            pix_q <= '0;
            dir_q <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    di_q         <= wr_data;
                2'd1:    pix_q[31:0]  <= wr_data;
                2'd2:    pix_q[63:32] <= wr_data;
                default: dir_q        <= wr_data[0];
            endcase
        end
    end

    assign di     = di_q;
    assign direct = dir_q;
    assign pixels = pix_q;
`endif

endmodule

// File: tb/tb_seg7_disp_arb.sv
// tb/tb_seg7_disp_arb.sv - self-checking bench for seg7_disp_arb

module tb_seg7_disp_arb;

    localparam int HOLD_MAX  = 4;
    localparam int BLINK_DIV = 8;

    logic        clk;
    logic        reset;
    logic [31:0] di;
    logic [63:0] pixels;
    logic        direct;

    seg7_disp_arb_if bus ();

    seg7_disp_arb #(
        .HOLD_MAX  (HOLD_MAX),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .di     (di),
        .pixels (pixels),
        .direct (direct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: owner is -1 (nobody), 0 or 1.
    int          m_own;
    int          m_cnt;
    int          m_last;
    int          m_bcnt;
    bit          m_phase;
    logic [31:0] m_di;
    logic [63:0] m_pix;
    bit          m_dir;
    bit          m_blink;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_bcnt  = 0;
        m_phase = 0;
        m_di    = '0;
        m_pix   = '0;
        m_dir   = 0;
        m_blink = 0;
    endtask

    task automatic model_step();
        bit          r [2];
        bit          w [2];
        logic [1:0]  a [2];
        logic [31:0] d [2];
        int          nown;
        int          o;
        r[0] = bus.req0; r[1] = bus.req1;
        w[0] = bus.wr0;  w[1] = bus.wr1;
        a[0] = bus.addr0; a[1] = bus.addr1;
        d[0] = bus.wdata0; d[1] = bus.wdata1;

        if (m_own >= 0 && w[m_own]) begin
            case (a[m_own])
                2'd0: m_di         = d[m_own];
                2'd1: m_pix[31:0]  = d[m_own];
                2'd2: m_pix[63:32] = d[m_own];
                default: begin
                    m_dir = d[m_own][0];
`ifdef SEG7_DISP_ARB_BLINK_EN
                    m_blink = d[m_own][1];
`endif
                end
            endcase
        end

        nown = m_own;
        if (m_own < 0) begin
            if (r[0] && r[1]) nown = 1 - m_last;
            else if (r[0])    nown = 0;
            else if (r[1])    nown = 1;
        end else begin
            o = 1 - m_own;
            if (!r[m_own])                                        nown = r[o] ? o : -1;
            else if (r[o] && HOLD_MAX != 0 && m_cnt == HOLD_MAX - 1) nown = o;
        end

        if (nown != m_own) begin
            m_cnt = 0;
            if (nown >= 0) m_last = nown;
        end else if (m_own >= 0 && r[1 - m_own] && m_cnt < HOLD_MAX - 1) begin
            m_cnt++;
        end
        m_own = nown;

        if (m_bcnt == BLINK_DIV - 1) begin
            m_bcnt  = 0;
            m_phase = !m_phase;
        end else begin
            m_bcnt++;
        end
    endtask

    task automatic check_all(input string tag);
        bit blank;
        blank = m_blink && m_phase;
        chk({tag, ".gnt0"},   64'(bus.gnt0), 64'(m_own == 0));
        chk({tag, ".gnt1"},   64'(bus.gnt1), 64'(m_own == 1));
        chk({tag, ".di"},     64'(di),       64'(m_di));
        chk({tag, ".pixels"}, pixels,        blank ? 64'd0 : m_pix);
        chk({tag, ".direct"}, 64'(direct),   64'(m_dir | blank));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 0; bus.wr0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.wr1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        do_reset();

        // First grant and a di write.
        tick("c1");
        bus.req0 = 1;
        tick("grant0");
        chk("gnt0_after_req", 64'(bus.gnt0), 64'd1);
        bus.wr0 = 1; bus.addr0 = 2'd0; bus.wdata0 = 32'h12345678;
        tick("write_di");
        chk("di_written", 64'(di), 64'h12345678);
        chk("direct_still0", 64'(direct), 64'd0);
        bus.wr0 = 0;
        bus.req0 = 0;
        tick("drop0");

        // Simultaneous requests after reset: port 0 wins, handover without gap.
        do_reset();
        bus.req0 = 1; bus.req1 = 1;
        tick("tie_first");
        chk("tie_gnt0", 64'(bus.gnt0), 64'd1);
        bus.req0 = 0;
        tick("handover");
        chk("handover_gnt1", 64'(bus.gnt1), 64'd1);
        bus.req1 = 0;
        tick("to_idle");
        chk("idle_no_gnt", 64'({bus.gnt0, bus.gnt1}), 64'd0);
        bus.req0 = 1; bus.req1 = 1;
        tick("tie_second");
        chk("tie2_gnt0", 64'(bus.gnt0), 64'd1);
        bus.req0 = 0; bus.req1 = 0;
        tick("tie_release");

        // Hold limit: port 1 owns, port 0 waits HOLD_MAX cycles.
        bus.req1 = 1;
        tick("own1");
        chk("own1_gnt1", 64'(bus.gnt1), 64'd1);
        bus.req0 = 1;
        for (int i = 1; i < HOLD_MAX; i++) begin
            tick("hold");
            chk("hold_gnt1", 64'(bus.gnt1), 64'd1);
        end
        tick("preempt");
        chk("preempt_gnt0", 64'(bus.gnt0), 64'd1);
        bus.req1 = 0;

        // Writes from the non-owner are dropped; owner writes take effect.
        bus.wr1 = 1; bus.addr1 = 2'd1; bus.wdata1 = 32'hDEADBEEF;
        tick("ignored_write");
        chk("pixels_unchanged", pixels, 64'd0);
        bus.wr1 = 0;
        bus.wr0 = 1; bus.addr0 = 2'd2; bus.wdata0 = 32'hFF00FF00;
        tick("write_pix_hi");
        bus.addr0 = 2'd3; bus.wdata0 = 32'h1;
        tick("write_mode");
        chk("pixels_hi", pixels, 64'hFF00FF00_00000000);
        chk("direct_set", 64'(direct), 64'd1);
        bus.wr0 = 0;

        // Asynchronous reset between edges during ownership.
        tick("pre_async");
        #2;
        reset = 1'b0;
        #1;
        chk("async_gnt0", 64'(bus.gnt0), 64'd0);
        chk("async_di", 64'(di), 64'd0);
        chk("async_pixels", pixels, 64'd0);
        chk("async_direct", 64'(direct), 64'd0);
        idle_inputs();
        do_reset();

`ifdef SEG7_DISP_ARB_BLINK_EN
        bus.req0 = 1;
        tick("blink_own");
        bus.wr0 = 1;
        bus.addr0 = 2'd1; bus.wdata0 = 32'hFFFFFFFF;
        tick("blink_lo");
        bus.addr0 = 2'd2;
        tick("blink_hi");
        bus.addr0 = 2'd3; bus.wdata0 = 32'h3;
        tick("blink_mode");
        bus.wr0 = 0;
        for (int i = 0; i < 4 * BLINK_DIV; i++) begin
            tick("blink");
            chk("blink_direct", 64'(direct), 64'd1);
        end
        idle_inputs();
        do_reset();
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) bus.req0 = !bus.req0;
            if ($urandom_range(0, 5) == 0) bus.req1 = !bus.req1;
            bus.wr0    = ($urandom_range(0, 2) == 0);
            bus.wr1    = ($urandom_range(0, 2) == 0);
            bus.addr0  = 2'($urandom_range(0, 3));
            bus.addr1  = 2'($urandom_range(0, 3));
            bus.wdata0 = $urandom;
            bus.wdata1 = $urandom;
            tick("rand");
            chk("rand_exclusive", 64'(bus.gnt0 & bus.gnt1), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_disp_arb.md
Name: seg7_disp_arb

Overview:
- Arbiter and register front-end that shares the 2x4 seven-segment display between two requesters: port 0 (CPU) and port 1 (debug monitor).
- The granted requester writes the display's data, pixel and mode registers.
- The block drives the display inputs di[31:0], pixels[63:0] and direct from registered state.
- Round-robin arbitration with a hold-time limit, so one requester cannot monopolise the display.

Parameters:
- HOLD_MAX, 1024: maximum cycles an owner keeps the grant while the other port requests; 0 = no limit.
- BLINK_DIV, 25000000: cycles per blink half-period (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req0  input  1  port 0 requests display ownership.
- wr0  input  1  port 0 write strobe.
- addr0  input  2  port 0 register address.
- wdata0  input  32  port 0 write data.
- gnt0  output  1  port 0 owns the display.
- req1, wr1, addr1, wdata1, gnt1: same as port 0, for port 1.
- di  output  32  hex digit data to the display.
- pixels  output  64  segment bitmaps to the display.
- direct  output  1  1 = display shows pixels, 0 = display decodes di.

Behaviour:
- Reset asserted:
  - gnt0=gnt1=0; di=0; pixels=0; direct=0.
  - FSM=IDLE; hold counter=0; last-owner=1, so port 0 wins the first tie.
- FSM states and transitions, evaluated each clk edge:
  - IDLE:
    - req0 only -> OWN0.
    - req1 only -> OWN1.
    - Both -> the port that is not last-owner.
    - Neither -> IDLE.
  - OWNx, own req still high:
    - Stay in OWNx while the other req is low, or HOLD_MAX=0, or counter < HOLD_MAX-1.
    - Counter = HOLD_MAX-1 and other req high -> preempt to OWN(other).
  - OWNx, own req low: -> OWN(other) if the other req is high, else IDLE.
- Grant outputs:
  - gnt0 = (state==OWN0); gnt1 = (state==OWN1). Both are registered, never high together.
  - Grant latency: req rising in cycle N gives gnt high in cycle N+1 when coming from IDLE.
  - Drop latency: gnt falls one cycle after the owner's req falls.
- Hold counter:
  - Clears on every state change; increments each cycle in OWNx while the other req is high.
  - Saturates at HOLD_MAX-1.
  - last-owner updates on entry to OWNx.
- Writes:
  - A write is accepted when wrx=1 and gntx=1 in the same cycle; the register updates at that edge.
  - A write in the last cycle of ownership (gnt still high) is accepted.
  - Writes from a non-granted port are ignored, with no error.
- Register map:
  - addr 0: di <= wdata.
  - addr 1: pixels[31:0] <= wdata.
  - addr 2: pixels[63:32] <= wdata.
  - addr 3: direct <= wdata[0]; blink_en <= wdata[1] (blink_en exists only with the optional feature; otherwise wdata[31:1] is ignored).
- Outputs change on the edge after an accepted write (1-cycle write-to-display latency).
- Register contents persist across ownership changes; only reset clears them.
- Reset asserted mid-ownership or mid-write: all state and outputs clear immediately, without waiting for clk. The write in progress is lost.

Optional Feature:
- Macro: SEG7_DISP_ARB_BLINK_EN.
- Defined:
  - Adds the blink_en control bit and a blink counter (wraps at BLINK_DIV-1) that toggles a phase bit.
  - While blink_en=1 and phase=1, outputs are forced to direct=1, pixels=0 (all segments dark). Stored registers are unchanged.
  - When phase=0, or blink_en=0, the stored values drive the outputs.
  - The counter and phase reset to 0.
- Not defined:
  - No counter and no blink_en bit; wdata[1] at addr 3 is ignored.
  - Outputs always equal the stored registers.

Test Plan:
- Reset, then req0=1 at cycle 2 -> gnt0=1 from cycle 3; write addr0=0 wdata0=32'h12345678 -> di=32'h12345678 the next cycle; direct=0.
- req0 and req1 both rise in the same cycle after reset -> gnt0 first. Drop req0 with req1 high -> gnt1 the next cycle with no idle gap. Later simultaneous request from IDLE -> gnt0 wins (last-owner=1).
- HOLD_MAX=4, port 1 owns, req0 held high -> gnt1 high exactly 4 cycles counted from req0 assertion, then gnt0.
- Port 1 writes addr 1 while gnt0=1 -> pixels unchanged. Port 0 writes addr 2 = 32'hFF00FF00 and addr 3 = 1 -> pixels[63:32]=32'hFF00FF00, direct=1.
- Reset pulsed low between clock edges during ownership -> gnt0, di, pixels and direct read 0 before the next edge.
- With SEG7_DISP_ARB_BLINK_EN, BLINK_DIV=8, addr 3 = 2'b11, pixels=all ones -> pixels alternates all-ones and 0 every 8 cycles; direct stays 1.
